datamover_apb2periph: RTL and testbench
=======================================

DATAMOVER_APB2PERIPH -- requirements
Module: datamover_apb2periph

Interface
REQ-001 Parameter ID, default 10, width in bits of the periph transaction ID.
REQ-002 Parameter ID_VALUE, default 0, constant ID stamped on every issued periph request.
REQ-003 Parameter TIMEOUT, default 255, range 2..255, cycles allowed from request launch to response before an error.
REQ-004 clk_i  input  1  single clock; all state is sampled on its rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 psel_i  input  1  APB select.
REQ-007 penable_i  input  1  APB access phase.
REQ-008 pwrite_i  input  1  APB write (1) / read (0).
REQ-009 paddr_i  input  32  APB byte address.
REQ-010 pwdata_i  input  32  APB write data.
REQ-011 pstrb_i  input  4  APB write byte strobes.
REQ-012 prdata_o  output  32  APB read data.
REQ-013 pready_o  output  1  APB transfer complete.
REQ-014 pslverr_o  output  1  APB error, valid only with pready_o.
REQ-015 periph_req  output  1  periph request.
REQ-016 periph_gnt  input  1  periph grant.
REQ-017 periph_add  output  32  periph word address.
REQ-018 periph_wen  output  1  periph write enable, active-low (0 = write).
REQ-019 periph_be  output  4  periph byte enables.
REQ-020 periph_data  output  32  periph write data.
REQ-021 periph_id  output  ID  periph request ID.
REQ-022 periph_r_data  input  32  periph response data.
REQ-023 periph_r_valid  input  1  periph response valid.
REQ-024 periph_r_id  input  ID  periph response ID.

Function
REQ-025 FSM states SHALL be IDLE, REQ, RESP, DONE; exactly one active at any time.
REQ-026 IDLE: on psel_i=1 and penable_i=1, latch address/data/strobe/direction, clear timeout counter, go to REQ next cycle.
REQ-027 Latched address SHALL be {paddr_i[31:2],2'b00}; paddr_i[1:0] ignored.
REQ-028 periph_be SHALL be latched pstrb_i for writes and 4'hF for reads; periph_wen SHALL be !pwrite_i latched.
REQ-029 REQ: periph_req=1, all periph request fields held stable until periph_gnt=1; on periph_gnt=1, go to RESP next cycle.
REQ-030 periph_req SHALL be 0 in IDLE, RESP and DONE.
REQ-031 RESP: on periph_r_valid=1 with periph_r_id==ID_VALUE, capture periph_r_data (reads) or 0 (writes) into prdata register, go to DONE with error=0.
REQ-032 periph_r_valid with mismatching periph_r_id, or asserted in IDLE, REQ or DONE, SHALL be ignored.
REQ-033 Writes SHALL also wait for periph_r_valid before completing.
REQ-034 Timeout counter (8 bits) SHALL increment every cycle in REQ and RESP; when it equals TIMEOUT-1 and no completion event occurs that cycle, go to DONE with error=1, prdata=0, periph_req dropped.
REQ-035 A completion event (gnt in REQ, matching r_valid in RESP) in the same cycle as timeout expiry SHALL take priority over the timeout.
REQ-036 DONE: pready_o=1 for exactly one cycle, prdata_o and pslverr_o valid, then return to IDLE unconditionally.
REQ-037 pready_o SHALL be 0 in all states except DONE; prdata_o and pslverr_o SHALL be 0 outside DONE.
REQ-038 Minimum latency: access phase at cycle 0, gnt at cycle 1, r_valid at cycle 2 -> pready_o=1 at cycle 3.
REQ-039 APB inputs changing or psel_i dropping after launch SHALL not affect the in-flight transaction, which completes through DONE.
REQ-040 A new access phase SHALL only be accepted in IDLE; back-to-back transfers incur no extra idle cycle beyond DONE->IDLE.

Reset
REQ-041 On rst_ni=0, asynchronously: state=IDLE, counter=0, periph_req=0, periph_add=0, periph_wen=1, periph_be=0, periph_data=0, pready_o=0, prdata_o=0, pslverr_o=0.
REQ-042 periph_id SHALL equal ID_VALUE at all times including reset.
REQ-043 Reset asserted mid-transaction SHALL abort it with no pready_o pulse; the first post-reset cycle is IDLE.

Verification
REQ-044 Read paddr=0x1000_0006, gnt at cycle 1, r_valid r_data=0xDEAD_BEEF at cycle 2 -> periph_add=0x1000_0004, be=4'hF, wen=1; pready_o=1, prdata_o=0xDEAD_BEEF, pslverr_o=0 at cycle 3.
REQ-045 Write pwdata=0x1234_5678, pstrb=4'b0011, gnt delayed 3 cycles -> req held with stable fields 4 cycles, wen=0, be=4'b0011; pready_o after r_valid, pslverr_o=0.
REQ-046 TIMEOUT=8, gnt never asserted -> pready_o=1, pslverr_o=1, prdata_o=0 at cycle 9 after launch; periph_req=0 from cycle 9.
REQ-047 r_valid with r_id!=ID_VALUE at cycle 2, matching r_valid at cycle 4 -> prdata_o from cycle-4 response, pready_o at cycle 5.
REQ-048 Matching r_valid in the exact timeout-expiry cycle -> pslverr_o=0, prdata_o = response data.
REQ-049 rst_ni pulsed low while in RESP -> no pready_o; next access completes normally with REQ-044 timing.

Source files
------------

// File: rtl/datamover_apb2periph.sv
// datamover_apb2periph: bridges a single APB access onto a periph req/gnt + r_valid bus with a response timeout.
//   clk_i, rst_ni                   : clock, asynchronous active-low reset
//   psel_i .. pstrb_i               : APB request inputs
//   prdata_o, pready_o, pslverr_o   : APB completion, driven only in DONE
//   periph_req .. periph_id         : periph request channel (periph_gnt back)
//   periph_r_data/r_valid/r_id      : periph response channel
module datamover_apb2periph #(
  parameter int              ID       = 10,
  parameter logic [ID-1:0]   ID_VALUE = '0,
  parameter int              TIMEOUT  = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          psel_i,
  input  logic          penable_i,
  input  logic          pwrite_i,
  input  logic [31:0]   paddr_i,
  input  logic [31:0]   pwdata_i,
  input  logic [3:0]    pstrb_i,
  output logic [31:0]   prdata_o,
  output logic          pready_o,
  output logic          pslverr_o,
  output logic          periph_req,
  input  logic          periph_gnt,
  output logic [31:0]   periph_add,
  output logic          periph_wen,
  output logic [3:0]    periph_be,
  output logic [31:0]   periph_data,
  output logic [ID-1:0] periph_id,
  input  logic [31:0]   periph_r_data,
  input  logic          periph_r_valid,
  input  logic [ID-1:0] periph_r_id
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic       expire, rsp_ok;
  assign periph_id = ID_VALUE;
  assign expire    = cnt == 8'(TIMEOUT - 1);
  assign rsp_ok    = periph_r_valid && periph_r_id == ID_VALUE;
  // Completion events are tested before expiry so a grant/response landing
  // on the last allowed cycle still succeeds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      periph_req  <= 1'b0;
      periph_add  <= '0;
      periph_wen  <= 1'b1;
      periph_be   <= '0;
      periph_data <= '0;
      pready_o    <= 1'b0;
      prdata_o    <= '0;
      pslverr_o   <= 1'b0;
    end else begin
      pready_o  <= 1'b0;
      prdata_o  <= '0;
      pslverr_o <= 1'b0;
      case (state)
        IDLE: if (psel_i && penable_i) begin
          state       <= REQ;
          cnt         <= '0;
          periph_req  <= 1'b1;
          periph_add  <= paddr_i & 32'hFFFF_FFFC;
          periph_wen  <= !pwrite_i;
          periph_be   <= pwrite_i ? pstrb_i : 4'hF;
          periph_data <= pwdata_i;
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (periph_gnt) begin
            state      <= RESP;
            periph_req <= 1'b0;
          end else if (expire) begin
            state      <= DONE;
            periph_req <= 1'b0;
            pready_o   <= 1'b1;
            pslverr_o  <= 1'b1;
          end
        end
        RESP: begin
          cnt <= cnt + 8'd1;
          if (rsp_ok) begin
            state    <= DONE;
            pready_o <= 1'b1;
            prdata_o <= periph_wen ? periph_r_data : '0;
          end else if (expire) begin
            state     <= DONE;
            pready_o  <= 1'b1;
            pslverr_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datamover_apb2periph.sv
// tb_datamover_apb2periph: directed checks of the APB-to-periph bridge.
module tb_datamover_apb2periph;
  localparam int            ID   = 10;
  localparam logic [ID-1:0] ID_V = 10'h2A5;
  logic          clk_i = 1'b0, rst_ni = 1'b1;
  logic          psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0]   paddr_i = '0, pwdata_i = '0;
  logic [3:0]    pstrb_i = '0;
  logic [31:0]   prdata_o;
  logic          pready_o, pslverr_o, periph_req, periph_wen;
  logic          periph_gnt = 1'b0, periph_r_valid = 1'b0;
  logic [31:0]   periph_add, periph_data, periph_r_data = '0;
  logic [3:0]    periph_be;
  logic [ID-1:0] periph_id, periph_r_id = ID_V;
  int tests = 0, fails = 0;

  datamover_apb2periph #(.ID(ID), .ID_VALUE(ID_V), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add),
    .periph_wen(periph_wen), .periph_be(periph_be), .periph_data(periph_data),
    .periph_id(periph_id), .periph_r_data(periph_r_data),
    .periph_r_valid(periph_r_valid), .periph_r_id(periph_r_id)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one access phase for a cycle, then scramble the APB inputs so any
  // leakage into the in-flight transfer shows up.
  task automatic launch(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    psel_i = 1'b1; penable_i = 1'b1; pwrite_i = wr; paddr_i = a; pwdata_i = d; pstrb_i = s;
    step();
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = ~wr;
    paddr_i = 32'hFFFF_FFFF; pwdata_i = 32'hCAFE_F00D; pstrb_i = 4'hF;
  endtask

  task automatic read_min(input string tag);
    launch(1'b0, 32'h1000_0006, 32'h0, 4'h3);
    chk({tag, "_c1_req"}, periph_req, 1);
    chk({tag, "_c1_add"}, periph_add, 32'h1000_0004);
    chk({tag, "_c1_be"}, periph_be, 4'hF);
    chk({tag, "_c1_wen"}, periph_wen, 1);
    chk({tag, "_c1_rdy"}, pready_o, 0);
    periph_gnt = 1'b1;
    step();
    chk({tag, "_c2_req"}, periph_req, 0);
    chk({tag, "_c2_rdy"}, pready_o, 0);
    periph_gnt = 1'b0; periph_r_valid = 1'b1; periph_r_id = ID_V; periph_r_data = 32'hDEAD_BEEF;
    step();
    chk({tag, "_c3_rdy"}, pready_o, 1);
    chk({tag, "_c3_rdata"}, prdata_o, 32'hDEAD_BEEF);
    chk({tag, "_c3_err"}, pslverr_o, 0);
    periph_r_valid = 1'b0;
    step();
    chk({tag, "_c4_rdy"}, pready_o, 0);
    chk({tag, "_c4_rdata"}, prdata_o, 0);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_rdy", pready_o, 0);
    chk("rst_rdata", prdata_o, 0);
    chk("rst_err", pslverr_o, 0);
    chk("rst_req", periph_req, 0);
    chk("rst_add", periph_add, 0);
    chk("rst_wen", periph_wen, 1);
    chk("rst_be", periph_be, 0);
    chk("rst_data", periph_data, 0);
    chk("rst_id", periph_id, ID_V);
    step();
    rst_ni = 1'b1;
    step();

    read_min("rd");

    // write, grant held off to cycle 4; a matching r_valid during REQ is ignored
    launch(1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011);
    for (int i = 1; i <= 4; i++) begin
      periph_r_valid = (i == 1); periph_r_data = 32'h1111_1111;
      chk("wr_req", periph_req, 1);
      chk("wr_add", periph_add, 32'h2000_0010);
      chk("wr_data", periph_data, 32'h1234_5678);
      chk("wr_be", periph_be, 4'b0011);
      chk("wr_wen", periph_wen, 0);
      chk("wr_rdy", pready_o, 0);
      periph_gnt = (i == 4);
      step();
    end
    periph_gnt = 1'b0;
    chk("wr_c5_req", periph_req, 0);
    chk("wr_c5_rdy", pready_o, 0);
    step();
    chk("wr_c6_rdy", pready_o, 0);
    periph_r_valid = 1'b1; periph_r_data = 32'hFFFF_FFFF;
    step();
    chk("wr_c7_rdy", pready_o, 1);
    chk("wr_c7_rdata", prdata_o, 0);
    chk("wr_c7_err", pslverr_o, 0);
    periph_r_valid = 1'b0;
    step();
    chk("wr_c8_rdy", pready_o, 0);

    // timeout: no grant ever
    launch(1'b0, 32'h3000_0000, 32'h0, 4'h0);
    for (int i = 1; i <= 8; i++) begin
      chk("to_req", periph_req, 1);
      chk("to_rdy", pready_o, 0);
      step();
    end
    chk("to_c9_rdy", pready_o, 1);
    chk("to_c9_err", pslverr_o, 1);
    chk("to_c9_rdata", prdata_o, 0);
    chk("to_c9_req", periph_req, 0);
    step();
    chk("to_c10_rdy", pready_o, 0);
    chk("to_c10_err", pslverr_o, 0);

    // mismatching response id ignored, matching one completes
    launch(1'b0, 32'h4000_0008, 32'h0, 4'h0);
    periph_gnt = 1'b1;
    step();
    periph_gnt = 1'b0; periph_r_valid = 1'b1; periph_r_id = 10'h2A4; periph_r_data = 32'hAAAA_AAAA;
    step();
    chk("id_c3_rdy", pready_o, 0);
    periph_r_valid = 1'b0; periph_r_id = ID_V;
    step();
    periph_r_valid = 1'b1; periph_r_data = 32'h5555_1234;
    step();
    chk("id_c5_rdy", pready_o, 1);
    chk("id_c5_rdata", prdata_o, 32'h5555_1234);
    chk("id_c5_err", pslverr_o, 0);
    periph_r_valid = 1'b0;
    step();
    chk("id_c6_rdy", pready_o, 0);

    // response arrives in the expiry cycle and wins
    launch(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    periph_gnt = 1'b1;
    step();
    periph_gnt = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      chk("pr_rdy", pready_o, 0);
      step();
    end
    periph_r_valid = 1'b1; periph_r_data = 32'h0BAD_CAFE;
    step();
    chk("pr_c9_rdy", pready_o, 1);
    chk("pr_c9_err", pslverr_o, 0);
    chk("pr_c9_rdata", prdata_o, 32'h0BAD_CAFE);
    periph_r_valid = 1'b0;
    step();

    // reset pulse while in RESP aborts silently
    launch(1'b0, 32'h5000_0000, 32'h0, 4'h0);
    periph_gnt = 1'b1;
    step();
    periph_gnt = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_rdy", pready_o, 0);
    chk("ar_req", periph_req, 0);
    chk("ar_add", periph_add, 0);
    chk("ar_wen", periph_wen, 1);
    rst_ni = 1'b1;
    periph_r_valid = 1'b1; periph_r_data = 32'h7777_7777;
    step();
    chk("ar_c3_rdy", pready_o, 0);
    chk("ar_c3_rdata", prdata_o, 0);
    periph_r_valid = 1'b0;
    read_min("ar_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
